// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and the printed-legend map for the 4x4 keypad.
// Imported by keypad_scan and keypad_debounce.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        REL_PEND
    } db_state_t;

    // Bit 4 set means no key was seen; otherwise bits 3:0 hold the hex legend.
    typedef logic [4:0] scan_result_t;
    localparam scan_result_t NONE = 5'h10;

    // Indexed by {row, col}: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    localparam logic [15:0][3:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a per-scan key result only after DEBOUNCE_SCANS
// identical scans, fires one registered strobe per press, and waits for release.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_done,
    input  logic [4:0] scan_result,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [8:0] move
);

    localparam logic [3:0] CNT_TARGET = 4'(DEBOUNCE_SCANS);

    db_state_t  state;
    db_state_t  state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [3:0] cand;
    logic [3:0] cand_next;
    logic       fire;
    logic       key_valid_next;
    logic [3:0] key_code_next;
    logic [8:0] move_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            cand  <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    // Reaching the target count is resolved after the case so that a target of 1
    // accepts or releases on the very scan that starts the run.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        fire       = 1'b0;
        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (scan_result != NONE) begin
                        cand_next  = scan_result[3:0];
                        cnt_next   = 4'd1;
                        state_next = PRESS_PEND;
                    end
                end
                PRESS_PEND: begin
                    if (scan_result == {1'b0, cand}) begin
                        cnt_next = (cnt < CNT_TARGET) ? cnt + 4'd1 : cnt;
                    end else if (scan_result == NONE) begin
                        cnt_next   = 4'd0;
                        state_next = IDLE;
                    end else begin
                        cand_next = scan_result[3:0];
                        cnt_next  = 4'd1;
                    end
                end
                HELD: begin
                    if (scan_result == NONE) begin
                        cnt_next   = 4'd1;
                        state_next = REL_PEND;
                    end
                end
                REL_PEND: begin
                    if (scan_result == NONE) begin
                        cnt_next = (cnt < CNT_TARGET) ? cnt + 4'd1 : cnt;
                    end else begin
                        cnt_next   = CNT_TARGET;
                        state_next = HELD;
                    end
                end
            endcase

            if (state_next == PRESS_PEND && cnt_next >= CNT_TARGET) begin
                fire       = 1'b1;
                state_next = HELD;
            end else if (state_next == REL_PEND && cnt_next >= CNT_TARGET) begin
                cnt_next   = 4'd0;
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        key_valid_next = fire;
        key_code_next  = fire ? cand_next : key_code;
        move_next      = 9'd0;
        if (fire && cand_next >= 4'd1 && cand_next <= 4'd9) begin
            move_next = 9'd1 << (cand_next - 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            move      <= 9'd0;
        end else begin
            key_valid <= key_valid_next;
            key_code  <= key_code_next;
            move      <= move_next;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: drives the keypad columns in turn, samples the synchronised rows
// once per column, and hands each full-scan result to keypad_debounce.
// Build option: KEYPAD_GHOST_REJECT_EN turns any multi-key scan into NONE.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [8:0]          move,
    output logic                key_valid,
    output logic [3:0]          key_code
);

    localparam int                SLOT_W    = $clog2(SCAN_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);

    logic [NUM_ROWS-1:0]         row_meta;
    logic [NUM_ROWS-1:0]         row_sync;
    logic [SLOT_W-1:0]           slot;
    logic [$clog2(NUM_COLS)-1:0] ci;
    logic                        last_slot;
    scan_result_t                acc_result;
    scan_result_t                col_result;
    scan_result_t                merged_result;
    scan_result_t                final_result;
    scan_result_t                scan_result;
    logic                        scan_done;

    assign last_slot = (slot == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
            ci   <= '0;
            col  <= 4'b1110;
        end else if (last_slot) begin
            slot <= '0;
            ci   <= ci + 2'd1;
            col  <= ~(4'b0001 << (ci + 2'd1));
        end else begin
            slot <= slot + SLOT_W'(1);
        end
    end

    // Rows are walked high to low so the lowest low row in this column wins;
    // an earlier column that already found a key keeps priority.
    always_comb begin
        col_result = NONE;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_sync[r]) begin
                col_result = {1'b0, key_at(2'(r), ci)};
            end
        end
        merged_result = (acc_result == NONE) ? col_result : acc_result;
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic [1:0] acc_lows;
    logic [1:0] lows_total;
    logic [2:0] col_lows;
    logic [2:0] lows_sum;

    // Low samples are counted across the whole scan and saturate at two.
    always_comb begin
        col_lows = 3'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            col_lows = col_lows + {2'b00, ~row_sync[r]};
        end
        lows_sum     = {1'b0, acc_lows} + col_lows;
        lows_total   = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
        final_result = (lows_total == 2'd2) ? NONE : merged_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_lows <= 2'd0;
        end else if (last_slot) begin
            acc_lows <= (ci == 2'd3) ? 2'd0 : lows_total;
        end
    end
`else
    always_comb begin
        final_result = merged_result;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_result  <= NONE;
            scan_result <= NONE;
            scan_done   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (last_slot) begin
                if (ci == 2'd3) begin
                    scan_result <= final_result;
                    scan_done   <= 1'b1;
                    acc_result  <= NONE;
                end else begin
                    acc_result <= merged_result;
                end
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .scan_done  (scan_done),
        .scan_result(scan_result),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .move       (move)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: behavioural 4x4 keypad driven scan by scan, checked against a
// run-length model of press acceptance and release.
module tb_keypad_scan;

    localparam int         SC       = 8;
    localparam int         DS       = 3;
    localparam int         SCAN_LEN = 4 * SC;
    localparam logic [4:0] NO_KEY   = 5'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [8:0]  move;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] cur_mask = 16'h0000;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    logic [3:0] tb_hex [16];

    logic       m_held;
    int         m_run;
    logic [4:0] m_val;
    logic [3:0] m_code;
    logic       exp_fire;

    keypad_scan #(
        .SCAN_CYCLES   (SC),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .move     (move),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    always #5 clk = ~clk;

    // Pressed key at bit r*4+c shorts row r to column c.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (cur_mask[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] move_of(input logic [3:0] code);
        if (code >= 4'd1 && code <= 4'd9) return 9'd1 << (code - 4'd1);
        return 9'd0;
    endfunction

    // One scan: column c sees only the keys pressed while it was driven.
    function automatic logic [4:0] scan_model(input logic [15:0] m0, m1, m2, m3);
        logic [15:0] mm [4];
        int          lows;
        logic [4:0]  res;
        mm   = '{m0, m1, m2, m3};
        lows = 0;
        res  = NO_KEY;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (mm[c][r*4+c]) begin
                    lows++;
                    if (res == NO_KEY) res = {1'b0, tb_hex[r*4+c]};
                end
            end
        end
`ifdef KEYPAD_GHOST_REJECT_EN
        if (lows >= 2) res = NO_KEY;
`endif
        return res;
    endfunction

    task automatic model_step(input logic [4:0] x);
        exp_fire = 1'b0;
        if (!m_held) begin
            if (x == NO_KEY) begin
                m_run = 0;
            end else begin
                if (m_run > 0 && x == m_val) m_run++;
                else begin
                    m_val = x;
                    m_run = 1;
                end
                if (m_run == DS) begin
                    exp_fire = 1'b1;
                    m_code   = x[3:0];
                    m_held   = 1'b1;
                    m_run    = 0;
                end
            end
        end else begin
            if (x == NO_KEY) begin
                m_run++;
                if (m_run == DS) begin
                    m_held = 1'b0;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] m0, m1, m2, m3, input int ncyc);
        logic [15:0] mm [4];
        logic [3:0]  exp_col;
        int          col_bad;
        int          extra;
        mm      = '{m0, m1, m2, m3};
        col_bad = 0;
        extra   = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i % SC == 0) cur_mask = mm[i/SC];
            @(negedge clk);
            exp_col = ~(4'b0001 << (((i + 1) / SC) % 4));
            if (col !== exp_col) col_bad++;
            if (key_valid === 1'b1) pulse_cnt++;
            if (i == 0) begin
                checkOutput("strobe", 32'(key_valid), 32'(exp_fire));
                checkOutput("key_code", 32'(key_code), 32'(m_code));
                checkOutput("move", 32'(move), 32'(exp_fire ? move_of(m_code) : 9'd0));
            end else if (key_valid !== 1'b0 || move !== 9'd0) begin
                extra++;
            end
        end
        checkOutput("col_walk", col_bad, 0);
        checkOutput("stray_strobe", extra, 0);
        if (ncyc == SCAN_LEN) model_step(scan_model(m0, m1, m2, m3));
    endtask

    task automatic run_held(input logic [15:0] mk, input int nscans);
        for (int n = 0; n < nscans; n++) applyStimulus(mk, mk, mk, mk, SCAN_LEN);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_col", 32'(col), 32'(4'b1110));
        checkOutput("rst_move", 32'(move), 0);
        checkOutput("rst_key_valid", 32'(key_valid), 0);
        checkOutput("rst_key_code", 32'(key_code), 0);
        rst      = 1'b0;
        m_held   = 1'b0;
        m_run    = 0;
        m_val    = NO_KEY;
        m_code   = 4'd0;
        exp_fire = 1'b0;
    endtask

    initial begin
        int          p0;
        int          kind;
        int          len;
        logic [15:0] mk;
        logic [15:0] b [4];

        tb_hex = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'h0, 4'hF, 4'hE, 4'hD};

        $display("[TB] reset and idle");
        do_reset();
        run_held(16'h0000, 2);

        $display("[TB] clean press of key 5");
        p0 = pulse_cnt;
        run_held(16'h0020, 7);
        checkOutput("press5_once", pulse_cnt - p0, 1);
        run_held(16'h0000, 4);

        $display("[TB] bouncing key 9");
        p0 = pulse_cnt;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) b[c] = ($urandom_range(0, 1) == 1) ? 16'h0400 : 16'h0000;
            b[2] = (k % 2 == 0) ? 16'h0400 : 16'h0000;
            applyStimulus(b[0], b[1], b[2], b[3], SCAN_LEN);
        end
        checkOutput("bounce_quiet", pulse_cnt - p0, 0);
        p0 = pulse_cnt;
        run_held(16'h0400, 5);
        checkOutput("bounce_settled_once", pulse_cnt - p0, 1);
        run_held(16'h0000, 4);

        $display("[TB] non-move key A");
        run_held(16'h0008, 4);
        run_held(16'h0000, 4);

        $display("[TB] chord of keys 2 and 6");
        p0 = pulse_cnt;
        run_held(16'h0042, 4);
`ifdef KEYPAD_GHOST_REJECT_EN
        checkOutput("chord_pulses", pulse_cnt - p0, 0);
`else
        checkOutput("chord_pulses", pulse_cnt - p0, 1);
`endif
        run_held(16'h0000, 4);

        $display("[TB] key 1 held through reset");
        p0 = pulse_cnt;
        run_held(16'h0001, 16);
        checkOutput("hold1_once", pulse_cnt - p0, 1);
        applyStimulus(16'h0001, 16'h0001, 16'h0001, 16'h0001, 13);
        do_reset();
        p0 = pulse_cnt;
        run_held(16'h0001, 6);
        checkOutput("rehold1_once", pulse_cnt - p0, 1);
        run_held(16'h0000, 4);

        $display("[TB] randomized segments");
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            mk   = 16'h0000;
            if (kind >= 1) mk[$urandom_range(0, 15)] = 1'b1;
            if (kind == 3) mk[$urandom_range(0, 15)] = 1'b1;
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) applyStimulus(mk, mk & 16'($urandom), mk, mk, SCAN_LEN);
                else run_held(mk, 1);
            end
        end
        run_held(16'h0000, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans the 4x4 matrix keypad on Pmod header JA and turns a debounced key press into a single-cycle one-hot `move` strobe. It sits directly upstream of the game logic and replaces the per-line button synchronisers on the keypad path. Each press produces exactly one strobe, and a held key never re-fires.

## Interface
- `SCAN_CYCLES`, default 100000: clock cycles each column is driven; 1 ms at 100 MHz. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full-scan results needed to accept a press or a release. Range 1–15.
- `clk`  in  1: system clock (100 MHz).
- `rst`  in  1: reset, synchronous, active-high.
- `row`  in  4: keypad rows, JA[7:4], active-low.
- `col`  out  4: keypad columns, JA[3:0], active-low. Exactly one bit is low at any time.
- `move`  out  9: one-hot, one-cycle strobe for keys 1–9. Key n sets `move[n-1]`.
- `key_valid`  out  1: one-cycle strobe that accompanies any accepted key (0–F).
- `key_code`  out  4: hex value of the last accepted key. Holds until the next accept.

## Operation
- **Input sync.** `row` passes through a 2-flop synchroniser before use.
- **Column scan.**
  - Column index `ci` cycles 0→1→2→3→0.
  - `col = ~(4'b0001 << ci)`.
  - A slot counter runs 0..SCAN_CYCLES-1 for each column.
  - The synchronised row is sampled in slot cycle SCAN_CYCLES-1.
- **Key map** (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- **Per-scan result.**
  - The first low row bit wins, searching c0..c3, then r0..r3 within each column.
  - If no row bit is low, the result is NONE.
  - The result is latched at the end of column 3.
- **Debounce FSM.** It is evaluated once per completed scan. `cnt` counts consecutive scans equal to the previous result and saturates at DEBOUNCE_SCANS.
  - IDLE: result ≠ NONE → PRESS_PEND, `cand` = result, `cnt` = 1.
  - PRESS_PEND:
    - result == `cand` → `cnt`++.
    - When `cnt` reaches DEBOUNCE_SCANS: emit strobe, → HELD.
    - result ≠ `cand` → IDLE (or restart PRESS_PEND with the new code if the result is not NONE).
  - HELD:
    - result == NONE → REL_PEND, `cnt` = 1.
    - Any other result, including a different key → stay in HELD, no strobe.
  - REL_PEND:
    - result == NONE → `cnt`++; at DEBOUNCE_SCANS → IDLE.
    - result ≠ NONE → HELD.
- **Strobe.**
  - `key_valid` = 1 and `key_code` = `cand`.
  - `move[cand-1]` = 1 only if `cand` is 1..9; otherwise `move` = 0.
- **Reset.**
  - `col` = 4'b1110, `ci` = 0, slot counter = 0, state IDLE, `cnt` = 0.
  - `move` = 0, `key_valid` = 0, `key_code` = 0, synchroniser flops = 4'b1111.
  - Reset mid-scan discards the partial scan and any pending candidate. A key held through reset is re-debounced and reported once.

## Timing
- Scan period is 4·SCAN_CYCLES cycles.
- A press that is stable from the start of a scan strobes 1 cycle after the end of the DEBOUNCE_SCANS-th scan.
- Row sampling lags the column change by 2 synchroniser cycles plus settling; SCAN_CYCLES ≥ 4 guarantees a settled sample.
- `move` and `key_valid` are high for exactly 1 cycle. They are never asserted on back-to-back cycles; the minimum spacing is DEBOUNCE_SCANS·2 scans (press + release).
- All outputs are registered.

## Configuration
- `KEYPAD_GHOST_REJECT_EN` defined:
  - A scan with two or more low samples is treated as NONE.
  - Multi-key chords are never accepted, and ghosted keys cannot leak through.
- `KEYPAD_GHOST_REJECT_EN` undefined: the first-in-priority-order key is taken, as described above.

## Structure
- **Package `keypad_pkg`:**
  - Debounce state enum (IDLE, PRESS_PEND, HELD, REL_PEND).
  - 5-bit result type with NONE = 5'h10.
  - The 16-entry row/column→hex key map constant.
  - NUM_ROWS = NUM_COLS = 4.
- **Sub-module `keypad_debounce`:**
  - Inputs: `clk`, `rst`, `scan_done`, `scan_result[4:0]`.
  - Outputs: the strobe, `key_code`, `move`.
  - Owns the FSM and `cnt`.
- **`keypad_scan` top:** synchroniser, slot/column counters, per-scan result capture.

## Test plan
All tests use SCAN_CYCLES=8 and DEBOUNCE_SCANS=3, giving a 32-cycle scan.
- **Reset:** assert `rst` for 2 cycles with row = 4'hF → `col` = 4'b1110, `move` = 0, `key_valid` = 0, `key_code` = 0. `col` steps to 4'b1101 after 8 cycles.
- **Clean press of key 5** (row1 low while col1 is low), held for 200 cycles → exactly one `move` = 9'b000010000 and `key_code` = 4'h5, ≤ 3 scans + 3 cycles after the first matching scan.
- **Bounce:** key 9 toggles every 20 cycles for 150 cycles, then is held for 150 cycles → no strobe during bouncing; one `move[8]` pulse after ≥ 3 stable scans.
- **Non-move key:** press A (row0, col3) → `key_valid` = 1, `key_code` = 4'hA, `move` = 0.
- **Held key and reset:** hold key 1 for 500 cycles → one pulse. Assert `rst` mid-scan while the key is still held → one further `move[0]` pulse after re-debounce, then none until release.
- **Two keys:** press 2 and 6 together.
  - Without the macro → `key_code` = 4'h2.
  - With `KEYPAD_GHOST_REJECT_EN` → no strobe.
